// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase sequencer: prescaled 1 s tick, per-phase BCD
// countdown, pedestrian-shortened greens and registered-phase light decode.
module traffic_phase_ctrl #(
  parameter int CLK_DIV  = 50000000,
  parameter int T_GREEN  = 9,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2,
  parameter int T_PED    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [3:0] count_bcd,
  output logic [2:0] phase,
  output logic       tick,
  output logic       walk
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  localparam logic [2:0] NS_GREEN  = 3'd0;
  localparam logic [2:0] NS_YELLOW = 3'd1;
  localparam logic [2:0] ALLRED_A  = 3'd2;
  localparam logic [2:0] EW_GREEN  = 3'd3;
  localparam logic [2:0] EW_YELLOW = 3'd4;
  localparam logic [2:0] ALLRED_B  = 3'd5;

  localparam logic [3:0] LD_GREEN  = 4'(T_GREEN);
  localparam logic [3:0] LD_YELLOW = 4'(T_YELLOW);
  localparam logic [3:0] LD_ALLRED = 4'(T_ALLRED);
  localparam logic [3:0] LD_PED    = 4'(T_PED);

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [2:0]    phase_q, phase_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          step;
  logic          is_green;
  logic          ped_apply;

  // Prescaler: tick_d doubles as the phase-advance strobe so the registered
  // tick and the count/phase update land on the same edge.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  assign step      = tick_d;
  assign is_green  = (phase_q == NS_GREEN) || (phase_q == EW_GREEN);
  assign ped_apply = step && is_green && pend_q;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (phase_q > ALLRED_B) begin
      phase_d = NS_GREEN;
      cnt_d   = LD_GREEN;
    end else if (step) begin
      if (ped_apply && (cnt_q > LD_PED)) begin
        cnt_d = LD_PED;
      end else if (cnt_q == 4'd1) begin
        case (phase_q)
          NS_GREEN:  begin phase_d = NS_YELLOW; cnt_d = LD_YELLOW; end
          NS_YELLOW: begin phase_d = ALLRED_A;  cnt_d = LD_ALLRED; end
          ALLRED_A:  begin phase_d = EW_GREEN;  cnt_d = LD_GREEN;  end
          EW_GREEN:  begin phase_d = EW_YELLOW; cnt_d = LD_YELLOW; end
          EW_YELLOW: begin phase_d = ALLRED_B;  cnt_d = LD_ALLRED; end
          default:   begin phase_d = NS_GREEN;  cnt_d = LD_GREEN;  end
        endcase
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  // A request on the consuming edge re-arms pending; it is seen next tick.
  assign pend_d = ped_req | (pend_q & ~ped_apply);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      phase_q <= NS_GREEN;
      cnt_q   <= LD_GREEN;
      pend_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    ns_light = L_RED;
    ew_light = L_RED;
    case (phase_q)
      NS_GREEN:  ns_light = L_GRN;
      NS_YELLOW: ns_light = L_YEL;
      EW_GREEN:  ew_light = L_GRN;
      EW_YELLOW: ew_light = L_YEL;
      default: ;
    endcase
  end

  assign walk      = (phase_q == ALLRED_A) || (phase_q == ALLRED_B);
  assign count_bcd = cnt_q;
  assign phase     = phase_q;
  assign tick      = tick_q;

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Sequences a two-way intersection (north-south, east-west) through green, yellow and all-red phases.
- Derives a one-second tick from the system clock.
- Maintains a per-phase countdown as a single BCD digit. `count_bcd` feeds the team's BCD-to-seven-segment decoder for the countdown display.
- Accepts a pedestrian request that shortens the current green.

Parameters:
- CLK_DIV, 50000000, clock cycles per countdown tick (≥2).
- T_GREEN, 9, green duration in ticks (1..9).
- T_YELLOW, 3, yellow duration in ticks (1..9).
- T_ALLRED, 2, all-red duration in ticks (1..9).
- T_PED, 3, green remaining after a pedestrian request is honoured (1..T_GREEN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; low pauses the sequence.
- ped_req  in  1  pedestrian request. Level or single-cycle pulse; sampled every clk.
- ns_light  out  3  {red, yellow, green} for north-south, one-hot.
- ew_light  out  3  {red, yellow, green} for east-west, one-hot.
- count_bcd  out  4  remaining ticks in the current phase, BCD 1..9.
- phase  out  3  current state encoding.
- tick  out  1  one-cycle pulse each elapsed tick.
- walk  out  1  pedestrian walk indication.

Behaviour:
- **Reset.** One clock domain; reset is asynchronous and active-low (`rst_n`); release is synchronised externally. While `rst_n` = 0:
  - phase = NS_GREEN (0), count_bcd = T_GREEN, prescaler = 0.
  - ped_pending = 0, tick = 0.
  - ns_light = 001, ew_light = 100, walk = 0.
- **States.** NS_GREEN = 0, NS_YELLOW = 1, ALLRED_A = 2, EW_GREEN = 3, EW_YELLOW = 4, ALLRED_B = 5. Codes 6 and 7 are illegal and go to NS_GREEN with count = T_GREEN on the next clk.
- **Transitions** (each taken on a tick when count_bcd = 1):
  - NS_GREEN → NS_YELLOW, load T_YELLOW.
  - NS_YELLOW → ALLRED_A, load T_ALLRED.
  - ALLRED_A → EW_GREEN, load T_GREEN.
  - EW_GREEN → EW_YELLOW, load T_YELLOW.
  - EW_YELLOW → ALLRED_B, load T_ALLRED.
  - ALLRED_B → NS_GREEN, load T_GREEN.
- **Light decode.** Decoded from the phase register only; no input-to-output combinational path.
  - NS_GREEN: ns = 001, ew = 100.
  - NS_YELLOW: ns = 010, ew = 100.
  - ALLRED_A and ALLRED_B: ns = 100, ew = 100.
  - EW_GREEN: ns = 100, ew = 001.
  - EW_YELLOW: ns = 100, ew = 010.
  - Never both directions non-red.
- **walk.** walk = 1 exactly in ALLRED_A and ALLRED_B.
- **Prescaler.**
  - Counts 0..CLK_DIV-1 while en = 1.
  - tick is registered: it is 1 in the cycle after the prescaler reaches CLK_DIV-1; the prescaler wraps to 0 at that point.
  - The phase/count update happens on the same clk edge that raises tick. count_bcd and phase therefore change coincident with tick = 1.
- **Countdown.**
  - On a tick with count_bcd > 1, count_bcd decrements by 1.
  - count_bcd is never 0 and never > 9.
  - First tick after reset lands CLK_DIV clocks after release.
- **Pedestrian request.**
  - ped_req = 1 on any clk (en high or low) sets ped_pending.
  - On a tick in NS_GREEN or EW_GREEN with ped_pending = 1:
    - if count_bcd > T_PED, count_bcd loads T_PED (no decrement this tick);
    - otherwise normal decrement or transition applies;
    - in both cases ped_pending clears.
  - In other states ped_pending is held until the next green tick.
  - ped_req coincident with a tick edge sets pending; it is applied no earlier than the following tick.
  - A request while pending has no further effect.
- **en = 0.** Prescaler, phase and count_bcd are frozen; tick = 0; lights hold. Resuming continues from the frozen prescaler value.
- **Reset mid-phase.** Immediately returns to the reset values above; ped_pending is lost.

Test Plan:
- **Reset and idle period.** CLK_DIV = 4, defaults; release rst_n → phase 0, ns = 001, ew = 100, count = 9; first tick 4 clks later, count 8.
- **Full cycle.** en = 1 for 28 ticks (112 clks) → sequence 0,1,2,3,4,5,0. Counts 9..1, 3..1, 2..1 per phase; walk high for exactly 4 ticks; lights never both non-red.
- **Pedestrian shortening.** Pulse ped_req at count = 7 in NS_GREEN → next tick count = 3, then 2, 1, then NS_YELLOW. Pulse at count = 2 → normal 1, then yellow; ped_pending cleared.
- **Pending carry-over.** ped_req during EW_YELLOW → ALLRED_B unaffected; first NS_GREEN tick loads 3 instead of 8.
- **Pause.** Drop en at count = 5 for 20 clks → no tick, count stays 5. Raise en → the next tick arrives after the remaining prescaler cycles, count 4.
- **Async reset mid-operation.** Assert rst_n low mid-EW_GREEN between clk edges → outputs return to reset values without a clk edge.
